// File: rtl/keypad_emulator_pkg.sv
// Shared constants, state encoding and small helpers for the keypad emulator.
package keypad_emulator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BOUNCE_IN  = 3'd1,
    ST_HOLD       = 3'd2,
    ST_BOUNCE_OUT = 3'd3,
    ST_GAP        = 3'd4
  } kp_state_t;

  // Released column lines read high through the pull-ups.
  localparam logic [3:0] KEYPAD_IDLE_COL = 4'b1111;

  // Key index layout: upper pair selects the row, lower pair the column.
  localparam int KEY_ROW_MSB = 3;
  localparam int KEY_ROW_LSB = 2;
  localparam int KEY_COL_MSB = 1;
  localparam int KEY_COL_LSB = 0;

  // An all-zero LFSR would lock up, so a zero seed falls back to this.
  localparam logic [7:0] LFSR_FALLBACK_SEED = 8'h01;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Press counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // 8-bit Fibonacci step, taps 8,6,5,4; feedback enters at bit 0.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/chatter_lfsr8.sv
// 8-bit chatter generator for contact bounce; advances only when enabled.
module chatter_lfsr8
  import keypad_emulator_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] seed,
  output logic [7:0] state
);

  logic [7:0] r_lfsr;

  // Load the seed on reset, otherwise step while enabled and hold when not.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lfsr <= seed;
    end else if (enable) begin
      r_lfsr <= lfsr8_next(r_lfsr);
    end
  end

  assign state = r_lfsr;

endmodule

// File: rtl/keypad_emulator.sv
// Passive 4x4 keypad model: answers a row-scanning keypad reader with the
// column pattern of one scheduled key press, including contact chatter.
module keypad_emulator
  import keypad_emulator_pkg::*;
#(
  parameter int         HOLD_W     = 20,
  parameter int         BOUNCE_W   = 8,
  parameter int         GAP_CYCLES = 16,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_key,
  input  logic [HOLD_W-1:0]   req_hold,
  input  logic [BOUNCE_W-1:0] req_bounce,
  input  logic [3:0]          keypadRow,
  output logic [3:0]          keypadCol,
  output logic                busy,
  output logic                done,
  output logic [15:0]         press_count
);

  // One down-counter serves every timed state, so it must fit the largest load.
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int CNT_W = max3(HOLD_W, BOUNCE_W, GAP_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);
  localparam logic [7:0] SEED_SAFE = (LFSR_SEED == 8'h00) ? LFSR_FALLBACK_SEED : LFSR_SEED;

  kp_state_t           r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [3:0]          r_key;
  logic [HOLD_W-1:0]   r_hold;
  logic [BOUNCE_W-1:0] r_bounce;
  logic                r_done;
  logic [15:0]         r_press_count;

  logic       w_in_bounce;
  logic       w_contact;
  logic       w_row_sel;
  logic [7:0] w_lfsr;
  logic       w_lfsr_unused;

  // A zero hold request still closes the contact for one cycle.
  function automatic logic [CNT_W-1:0] hold_load(input logic [HOLD_W-1:0] h);
    return (h == '0) ? CNT_ONE : CNT_W'(h);
  endfunction

  assign w_in_bounce = (r_state == ST_BOUNCE_IN) || (r_state == ST_BOUNCE_OUT);

  chatter_lfsr8 u_chatter (
    .clk    (clk),
    .rst    (rst),
    .enable (w_in_bounce),
    .seed   (SEED_SAFE),
    .state  (w_lfsr)
  );

  // Only bit 0 drives the contact; the rest of the state just decorrelates it.
  assign w_lfsr_unused = &{1'b0, w_lfsr[7:1]};

  // Press sequencer: capture, chatter in, solid hold, chatter out, forced gap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_key         <= '0;
      r_hold        <= '0;
      r_bounce      <= '0;
      r_done        <= 1'b0;
      r_press_count <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_key    <= req_key;
            r_hold   <= req_hold;
            r_bounce <= req_bounce;
            if (req_bounce != '0) begin
              r_state <= ST_BOUNCE_IN;
              r_cnt   <= CNT_W'(req_bounce);
            end else begin
              r_state       <= ST_HOLD;
              r_cnt         <= hold_load(req_hold);
              r_press_count <= sat_inc16(r_press_count);
            end
          end
        end
        ST_BOUNCE_IN: begin
          if (r_cnt == CNT_ONE) begin
            r_state       <= ST_HOLD;
            r_cnt         <= hold_load(r_hold);
            r_press_count <= sat_inc16(r_press_count);
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_HOLD: begin
          if (r_cnt == CNT_ONE) begin
            if (r_bounce != '0) begin
              r_state <= ST_BOUNCE_OUT;
              r_cnt   <= CNT_W'(r_bounce);
            end else if (GAP_CYCLES != 0) begin
              r_state <= ST_GAP;
              r_cnt   <= GAP_LOAD;
            end else begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_BOUNCE_OUT: begin
          if (r_cnt == CNT_ONE) begin
            if (GAP_CYCLES != 0) begin
              r_state <= ST_GAP;
              r_cnt   <= GAP_LOAD;
            end else begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_GAP: begin
          if (r_cnt == CNT_ONE) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Contact is solid in HOLD and follows the chatter bit while bouncing.
  assign w_contact = (r_state == ST_HOLD) || (w_in_bounce && w_lfsr[0]);
  assign w_row_sel = ~keypadRow[r_key[KEY_ROW_MSB:KEY_ROW_LSB]];

  // Wired-AND matrix: a column is pulled low only through the closed key.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col
      assign keypadCol[gi] = KEYPAD_IDLE_COL[gi] &
                             ~(w_contact && w_row_sel && (r_key[KEY_COL_MSB:KEY_COL_LSB] == 2'(gi)));
    end
  endgenerate

  assign req_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign press_count = r_press_count;

endmodule
